// File: rtl/osc_cfg_pkg.sv
// Shared constants and types for the DDS oscillator config controller.
// Register map, CTRL bit layout and reset values.
package osc_cfg_pkg;

  localparam logic [2:0] ADDR_TUNE_LO = 3'd0;
  localparam logic [2:0] ADDR_TUNE_HI = 3'd1;
  localparam logic [2:0] ADDR_MOD_LO  = 3'd2;
  localparam logic [2:0] ADDR_MOD_HI  = 3'd3;
  localparam logic [2:0] ADDR_CTRL    = 3'd4;
  localparam logic [2:0] ADDR_COMMIT  = 3'd5;

  localparam int CTRL_SEL_LSB = 0;
  localparam int CTRL_RUN     = 3;

  localparam int          M_DEF   = 12;
  localparam logic [15:0] MOD_RST = 16'(1) << (M_DEF - 1);

  typedef enum logic {
    ST_IDLE,
    ST_PEND
  } cfg_state_e;

  // Mid-scale PWM reset value for an arbitrary modulation width
  function automatic logic [15:0] mod_rst(int unsigned m);
    return 16'(1) << (m - 1);
  endfunction

endpackage

// File: rtl/osc_cfg_if.sv
// Byte-wide register write / readback bus from the chip pins.
// Always ready: one write per cycle that wr_en is high.
interface osc_cfg_if;
  logic       wr_en;
  logic [2:0] addr;
  logic [7:0] wdata;
  logic [2:0] raddr;
  logic [7:0] rdata;

  modport master (
    output wr_en, addr, wdata, raddr,
    input  rdata
  );

  modport slave (
    input  wr_en, addr, wdata, raddr,
    output rdata
  );
endinterface

// File: rtl/osc_ce_prescaler.sv
// Free-running 0..DIV-1 counter producing the oscillator tick.
// Runs regardless of the run bit so commit timing stays on the CE grid.
module osc_ce_prescaler #(
  parameter int DIV  = 18,
  parameter int DIVW = 5
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o
);

  logic [DIVW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == DIVW'(DIV - 1));
  assign cnt_d  = tick_o ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/osc_cfg_ctrl.sv
// Shadow register file, commit FSM and readback for the DDS oscillator.
// Active settings change only on a tick so the accumulator never tears.
module osc_cfg_ctrl
  import osc_cfg_pkg::*;
#(
  parameter int TUNE = 16,
  parameter int M    = 12,
  parameter int DIV  = 18,
  parameter int DIVW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  osc_cfg_if.slave        bus,
  output logic [TUNE-1:0] tuningW,
  output logic [2:0]      sel,
  output logic [M-1:0]    mod,
  output logic            CE,
  output logic            pending
);

  localparam logic [M-1:0] MOD_INIT = M'(mod_rst(M));

  logic [TUNE-1:0] tune_q, tune_d;
  logic [M-1:0]    smod_q, smod_d;
  logic [2:0]      ssel_q, ssel_d;
  logic            srun_q, srun_d;

  logic [TUNE-1:0] tw_q;
  logic [M-1:0]    amod_q;
  logic [2:0]      asel_q;
  logic            arun_q;

  cfg_state_e      state_q;
  logic            commit;
  logic            tick;

  osc_ce_prescaler #(
    .DIV  (DIV),
    .DIVW (DIVW)
  ) u_presc (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick_o (tick)
  );

  always_comb begin
    tune_d = tune_q;
    smod_d = smod_q;
    ssel_d = ssel_q;
    srun_d = srun_q;
    commit = 1'b0;
    if (bus.wr_en) begin
      unique case (1'b1)
        (bus.addr == ADDR_TUNE_LO): tune_d[7:0] = bus.wdata;
        (bus.addr == ADDR_TUNE_HI):
          tune_d[TUNE-1:8] = bus.wdata[TUNE-9:0];
        (bus.addr == ADDR_MOD_LO):  smod_d[7:0] = bus.wdata;
        (bus.addr == ADDR_MOD_HI):
          smod_d[M-1:8] = bus.wdata[M-9:0];
        (bus.addr == ADDR_CTRL): begin
          ssel_d = bus.wdata[CTRL_SEL_LSB +: 3];
          srun_d = bus.wdata[CTRL_RUN];
        end
        (bus.addr == ADDR_COMMIT):  commit = 1'b1;
        default: ;
      endcase
    end
  end

  // Apply reads the _q shadows, so a same-cycle shadow write misses it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tune_q  <= '0;
      smod_q  <= MOD_INIT;
      ssel_q  <= '0;
      srun_q  <= 1'b0;
      tw_q    <= '0;
      amod_q  <= MOD_INIT;
      asel_q  <= '0;
      arun_q  <= 1'b0;
      state_q <= ST_IDLE;
    end else begin
      tune_q <= tune_d;
      smod_q <= smod_d;
      ssel_q <= ssel_d;
      srun_q <= srun_d;
      unique case (state_q)
        ST_IDLE: if (commit) state_q <= ST_PEND;
        ST_PEND: if (tick) begin
          tw_q    <= tune_q;
          amod_q  <= smod_q;
          asel_q  <= ssel_q;
          arun_q  <= srun_q;
          state_q <= commit ? ST_PEND : ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tuningW = tw_q;
  assign mod     = amod_q;
  assign sel     = asel_q;
  assign pending = (state_q == ST_PEND);
  assign CE      = tick & arun_q;

  always_comb begin
    bus.rdata = 8'h00;
    unique case (1'b1)
      (bus.raddr == ADDR_TUNE_LO): bus.rdata = tune_q[7:0];
      (bus.raddr == ADDR_TUNE_HI): bus.rdata = 8'(tune_q[TUNE-1:8]);
      (bus.raddr == ADDR_MOD_LO):  bus.rdata = smod_q[7:0];
      (bus.raddr == ADDR_MOD_HI):  bus.rdata = 8'(smod_q[M-1:8]);
      (bus.raddr == ADDR_CTRL):    bus.rdata = {4'h0, srun_q, ssel_q};
      (bus.raddr == ADDR_COMMIT):  bus.rdata = {7'h00, pending};
      default: ;
    endcase
  end

endmodule

// File: tb/tb_osc_cfg_ctrl.sv
// Directed scoreboard bench for osc_cfg_ctrl.
// Expectations are queued with stimulus and popped when outputs are sampled.
module tb_osc_cfg_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] tuningW;
  logic [2:0]  sel;
  logic [11:0] mod;
  logic        CE;
  logic        pending;

  int tests = 0;
  int fails = 0;
  int mcnt  = 0;

  string       tagq[$];
  logic [31:0] expq[$];

  osc_cfg_if bus();

  osc_cfg_ctrl #(
    .TUNE (16),
    .M    (12),
    .DIV  (18),
    .DIVW (5)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .tuningW (tuningW),
    .sel     (sel),
    .mod     (mod),
    .CE      (CE),
    .pending (pending)
  );

  always #5 clk = ~clk;

  // Reference prescaler phase
  always @(posedge clk) begin
    if (!rst_n) mcnt <= 0;
    else        mcnt <= (mcnt == 17) ? 0 : mcnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string t, input logic [31:0] v);
    tagq.push_back(t);
    expq.push_back(v);
  endtask

  task automatic chk(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    tests++;
    if (expq.size() == 0) begin
      fails++;
      $error("FAIL scoreboard_empty: got %0h required nothing", obs);
    end else begin
      t = tagq.pop_front();
      e = expq.pop_front();
      assert (obs === e) else begin
        fails++;
        $error("FAIL %s: got %0h required %0h", t, obs, e);
      end
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    bus.wr_en = 1'b1;
    bus.addr  = a;
    bus.wdata = d;
    step();
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_cnt(input int target);
    int n = 0;
    while (mcnt != target && n < 40) begin
      step();
      n++;
    end
    if (mcnt != target) begin
      tests++;
      fails++;
      $error("FAIL wait_cnt: got %0d required %0d", mcnt, target);
    end
  endtask

  task automatic rd(input logic [2:0] a);
    bus.raddr = a;
    #1;
  endtask

  initial begin
    int n;
    int ces;
    bus.wr_en = 1'b1;
    bus.addr  = 3'd4;
    bus.wdata = 8'hFF;
    bus.raddr = 3'd4;
    rst_n     = 1'b0;
    repeat (3) step();
    push("rst_tw", 32'h0);     chk(32'(tuningW));
    push("rst_sel", 32'h0);    chk(32'(sel));
    push("rst_mod", 32'h800);  chk(32'(mod));
    push("rst_ce", 32'h0);     chk(32'(CE));
    push("rst_pend", 32'h0);   chk(32'(pending));
    push("rst_rd4", 32'h0);    chk(32'(bus.rdata));
    bus.wr_en = 1'b0;
    rst_n     = 1'b1;
    step();

    // Basic commit
    wr(3'd0, 8'h34);
    wr(3'd1, 8'h12);
    wr(3'd4, 8'h0B);
    wr(3'd5, 8'h00);
    push("bc_pend", 32'h1);    chk(32'(pending));
    push("bc_tw_hold", 32'h0); chk(32'(tuningW));
    rd(3'd5);
    push("bc_rd5", 32'h1);     chk(32'(bus.rdata));
    push("bc_tw", 32'h1234);
    push("bc_sel", 32'h3);
    push("bc_pend0", 32'h0);
    push("bc_ce_first", 32'd17);
    push("bc_ce_width", 32'h0);
    push("bc_ce_period", 32'd18);
    wait_cnt(17);
    step();
    chk(32'(tuningW));
    chk(32'(sel));
    chk(32'(pending));
    n = 0;
    while (!CE && n < 60) begin step(); n++; end
    chk(32'(n));
    step();
    chk(32'(CE));
    n = 1;
    while (!CE && n < 60) begin step(); n++; end
    chk(32'(n));

    // Atomicity
    wr(3'd0, 8'hFF);
    for (int i = 0; i < 100; i++) begin
      step();
      if (i % 25 == 24) begin
        push("at_hold", 32'h1234);
        chk(32'(tuningW));
      end
    end
    wr(3'd1, 8'h00);
    wr(3'd5, 8'h00);
    push("at_apply", 32'h00FF);
    wait_cnt(17);
    step();
    chk(32'(tuningW));

    // Commit written in the tick cycle waits a full period
    wr(3'd0, 8'h11);
    wait_cnt(17);
    wr(3'd5, 8'h00);
    push("tk_pend", 32'h1);    chk(32'(pending));
    repeat (17) step();
    push("tk_noapply", 32'h00FF); chk(32'(tuningW));
    push("tk_pend2", 32'h1);      chk(32'(pending));
    step();
    push("tk_apply", 32'h0011);   chk(32'(tuningW));
    push("tk_pend0", 32'h0);      chk(32'(pending));

    // Shadow write colliding with the apply edge
    wr(3'd2, 8'hAA);
    wr(3'd3, 8'h00);
    wr(3'd5, 8'h00);
    wait_cnt(17);
    wr(3'd2, 8'h55);
    push("co_mod", 32'h0AA);   chk(32'(mod));
    push("co_pend", 32'h0);    chk(32'(pending));
    rd(3'd2);
    push("co_rd2", 32'h55);    chk(32'(bus.rdata));
    rd(3'd6);
    push("co_rd6", 32'h00);    chk(32'(bus.rdata));

    // Run off: last CE at the apply tick, none after
    wr(3'd4, 8'h03);
    wr(3'd5, 8'h00);
    wait_cnt(17);
    push("ro_last_ce", 32'h1); chk(32'(CE));
    ces = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (CE) ces++;
    end
    push("ro_no_ce", 32'h0);   chk(32'(ces));

    // Reset one clk before the apply tick drops the commit
    wr(3'd0, 8'h77);
    wr(3'd5, 8'h00);
    wait_cnt(16);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    push("rp_pend", 32'h0);    chk(32'(pending));
    push("rp_tw", 32'h0);      chk(32'(tuningW));
    push("rp_mod", 32'h800);   chk(32'(mod));
    push("rp_sel", 32'h0);     chk(32'(sel));
    rd(3'd0);
    push("rp_rd0", 32'h0);     chk(32'(bus.rdata));
    repeat (25) step();
    push("rp_tw_late", 32'h0); chk(32'(tuningW));
    push("rp_pend_late", 32'h0); chk(32'(pending));

    if (expq.size() != 0) begin
      tests++;
      fails++;
      $error("FAIL scoreboard_leftover: got %0d required 0", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/osc_cfg_ctrl.md
Name: osc_cfg_ctrl

Overview:
- Configuration and sequencing controller for the DDS oscillator core.
- Accepts byte-wide register writes from the chip pins into shadow registers.
- Generates the oscillator clock-enable from a prescaler.
- Transfers shadow settings (tuning word, waveform select, PWM modulation, run) to the active outputs atomically, only on a clock-enable boundary, so the phase accumulator never sees a half-updated tuning word.

Parameters:
- TUNE, 16, tuning word width (must be 9..16).
- M, 12, PWM modulation word width (must be 9..16).
- DIV, 18, clk cycles per CE pulse (2..31).
- DIVW, 5, prescaler counter width; 2^DIVW >= DIV.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- wr_en  in  1  write strobe; one write per cycle it is high.
- addr  in  3  register address.
- wdata  in  8  write data.
- raddr  in  3  readback address.
- rdata  out  8  combinational readback of the shadow register at raddr.
- tuningW  out  TUNE  active tuning word to the oscillator.
- sel  out  3  active waveform select.
- mod  out  M  active PWM modulation word.
- CE  out  1  oscillator clock enable, one clk wide.
- pending  out  1  commit requested, not yet applied.

Behaviour:
- Register map (shadow registers):
  - 0 TUNE_LO = tuning[7:0]
  - 1 TUNE_HI = tuning[TUNE-1:8] (upper wdata bits ignored)
  - 2 MOD_LO = mod[7:0]
  - 3 MOD_HI = mod[M-1:8]
  - 4 CTRL: bits[2:0] = sel, bit3 = run, bits[7:4] ignored
  - 5 COMMIT: any write sets pending; data ignored
  - 6, 7: writes ignored, read 0x00
- rdata: unused bits read 0. Address 5 reads {7'b0, pending}.
- Reset (rst_n=0 at a clk edge), shadow and active registers alike:
  - tuning = 0, mod = 2^(M-1) (0x800), sel = 0, run = 0.
  - cnt = 0, pending = 0.
  - Outputs after reset: CE = 0, tuningW = 0, sel = 0, mod = 0x800, pending = 0.
  - Reset mid-operation discards any pending commit and any partially written shadow values.
- Prescaler:
  - cnt counts 0..DIV-1 and wraps; it runs continuously and is independent of run.
  - tick = (cnt == DIV-1).
  - CE = tick & run_active, decoded from registered state. CE period = DIV clks.
- Commit sequencing (states IDLE, PEND):
  - IDLE -> PEND on a write to address 5.
  - PEND -> IDLE on the first cycle with tick=1 that follows the commit write. At that edge all active registers load from the shadow registers. New values are visible the next cycle.
  - A commit write in a cycle where tick=1 does not apply at that tick; it waits for the next tick, up to DIV cycles later.
  - A shadow write in the same cycle as an apply does not take part; the apply uses the pre-write shadow value. The write lands in the shadow and needs another commit.
  - Shadow writes while in PEND are allowed; the apply takes the latest shadow contents.
  - A second commit write while in PEND is absorbed (stays PEND).
- CE in the apply cycle uses the old run_active. A run 0->1 commit produces its first CE DIV cycles after the apply tick. A run 1->0 commit: the CE at the apply tick is still issued; no CE after that.
- pending is the registered PEND state.
- Shadow writes never disturb the active outputs before commit.
- No multi-cycle handshake: the write interface is always ready.

Decomposition:
- Shared package holds:
  - register address constants (ADDR_TUNE_LO..ADDR_COMMIT)
  - CTRL bit positions (CTRL_SEL_LSB = 0, CTRL_RUN = 3)
  - reset constant MOD_RST = 2^(M-1)
- Sub-module osc_ce_prescaler: counter plus tick output, parameterised by DIV and DIVW.
- Register file, commit FSM and readback stay in the top of this block.

Test Plan:
- Reset: hold rst_n=0 for 3 clks with wr_en=1 at addr 4 -> tuningW=0, sel=0, mod=0x800, CE=0, pending=0, rdata at raddr 4 = 0x00.
- Basic commit: write 0x34 to addr 0, 0x12 to addr 1, 0x0B to addr 4, then commit -> pending=1; tuningW stays 0 until the next tick. Then tuningW=0x1234 and sel=3 one clk after the tick, pending=0, first CE exactly 18 clks after the apply tick, then CE every 18 clks.
- Atomicity: with run=1 and tuningW=0x1234, write TUNE_LO=0xFF only, no commit, for 100 clks -> tuningW stays 0x1234. Then write TUNE_HI=0x00 and commit -> tuningW=0x00FF after the next tick.
- Commit on tick boundary: issue the commit write exactly in the cycle cnt=17 -> no apply at that tick; apply at the following tick, 18 clks later.
- Same-cycle collision: write MOD_LO=0x55 in the apply cycle, with shadow mod=0x0AA committed -> mod=0x0AA after apply; rdata at raddr 2 = 0x55; pending=0.
- Run off and reset mid-pending: commit CTRL run=0 -> the CE at the apply tick is still issued, CE=0 forever after, prescaler keeps counting. Then commit-write, assert rst_n=0 one clk before the tick -> pending=0, outputs at reset values, no apply.
